// File: rtl/gpio_bank.sv
// gpio_bank: bus-mapped GPIO bank with output, direction and synchronized input
// registers plus set/clear/toggle write ports.
// Optional rising-edge interrupts (IE, IFLAG, irq) are built only when the macro
// GPIO_BANK_IRQ_EN is defined; otherwise 0x006/0x007 read as zero and irq is 0.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      address,
    input  logic [31:0]      data,
    input  logic             rden,
    input  logic             wren,
    input  logic             clken,
    output logic [31:0]      q,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    localparam logic [10:0] ADDR_OUT   = 11'h000;
    localparam logic [10:0] ADDR_DIR   = 11'h001;
    localparam logic [10:0] ADDR_IN    = 11'h002;
    localparam logic [10:0] ADDR_SET   = 11'h003;
    localparam logic [10:0] ADDR_CLR   = 11'h004;
    localparam logic [10:0] ADDR_TGL   = 11'h005;
    localparam logic [10:0] ADDR_IE    = 11'h006;
    localparam logic [10:0] ADDR_IFLAG = 11'h007;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [31:0]      rd_word;
    logic             wr_en;
    logic             rd_en;
    logic             data_unused;

    // Bus strobes only count when the access qualifier is high.
    assign wr_en  = clken & wren;
    assign rd_en  = clken & rden;
    assign wdata  = data[WIDTH-1:0];
    assign in_val = sync_q[SYNC_STAGES-1];

    // Upper data bits beyond WIDTH are deliberately ignored.
    assign data_unused = ^data;

    assign pin_out = out_q;
    assign pin_oe  = dir_q;

`ifdef GPIO_BANK_IRQ_EN
    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] ie_q;
    logic [WIDTH-1:0] iflag_q;
    logic [WIDTH-1:0] in_dly_q;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] w1c_mask;
    logic [2:0]       arm_cnt_q;
    logic             armed;

    // Edges only count once the synchronizer has flushed its post-reset contents.
    assign armed    = (arm_cnt_q == ARM_MAX);
    assign edge_hit = armed ? (in_val & ~in_dly_q) : '0;
    assign w1c_mask = (wr_en && (address == ADDR_IFLAG)) ? wdata : '0;

    // Interrupt state: enables, sticky flags (set beats clear), delayed copy, arm counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie_q      <= '0;
            iflag_q   <= '0;
            in_dly_q  <= '0;
            arm_cnt_q <= '0;
        end else begin
            in_dly_q <= in_val;
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + 3'd1;
            end
            if (wr_en && (address == ADDR_IE)) begin
                ie_q <= wdata;
            end
            iflag_q <= (iflag_q & ~w1c_mask) | edge_hit;
        end
    end

    assign irq = |(iflag_q & ie_q);
`else
    assign irq = 1'b0;
`endif

    // Read mux: zero-extended register contents, zero for write-only or unmapped words.
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_OUT:   rd_word[WIDTH-1:0] = out_q;
            ADDR_DIR:   rd_word[WIDTH-1:0] = dir_q;
            ADDR_IN:    rd_word[WIDTH-1:0] = in_val;
`ifdef GPIO_BANK_IRQ_EN
            ADDR_IE:    rd_word[WIDTH-1:0] = ie_q;
            ADDR_IFLAG: rd_word[WIDTH-1:0] = iflag_q;
`endif
            default:    rd_word = '0;
        endcase
    end

    // Output and direction registers, including the set/clear/toggle write aliases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_OUT: out_q <= wdata;
                ADDR_DIR: dir_q <= wdata;
                ADDR_SET: out_q <= out_q | wdata;
                ADDR_CLR: out_q <= out_q & ~wdata;
                ADDR_TGL: out_q <= out_q ^ wdata;
                default:  ;
            endcase
        end
    end

    // Registered read data; it samples pre-write values so read-during-write returns old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (rd_en) begin
            q <= rd_word;
        end
    end

    // Input synchronizer runs every cycle regardless of bus activity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed plus randomized bench for gpio_bank with a behavioural model.
// Define GPIO_BANK_IRQ_EN for both bench and RTL to exercise the interrupt build.
module tb_gpio_bank;

    localparam int W = 8;
    localparam int S = 2;
    localparam logic [31:0] MASK = 32'h0000_00FF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [10:0]   address = '0;
    logic [31:0]   data = '0;
    logic          rden = 1'b0;
    logic          wren = 1'b0;
    logic          clken = 1'b0;
    logic [31:0]   q;
    logic [W-1:0]  pin_in = '0;
    logic [W-1:0]  pin_out;
    logic [W-1:0]  pin_oe;
    logic          irq;

    int tests = 0;
    int errors = 0;
    bit compare_on = 1'b0;

    gpio_bank #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data(data),
        .rden(rden), .wren(wren), .clken(clken), .q(q),
        .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state: registers as plain words, pin samples as a history list.
    logic [31:0]  m_out, m_dir, m_ie, m_iflag, m_q;
    logic [W-1:0] hist [0:S];
    logic [W-1:0] m_in_now, m_dly, m_hits;
    logic [31:0]  m_wd;
    int           m_rel;

    function automatic logic [31:0] readModel(input logic [10:0] a, input logic [W-1:0] in_now);
        case (a)
            11'h000: return m_out;
            11'h001: return m_dir;
            11'h002: return {24'b0, in_now};
`ifdef GPIO_BANK_IRQ_EN
            11'h006: return m_ie;
            11'h007: return m_iflag;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic modelIrq();
`ifdef GPIO_BANK_IRQ_EN
        return |(m_iflag & m_ie);
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model on each rising edge from the inputs held across that edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_out = 0; m_dir = 0; m_ie = 0; m_iflag = 0; m_q = 0; m_rel = 0;
            for (int i = 0; i <= S; i++) hist[i] = '0;
        end else begin
            m_in_now = hist[S-1];
            m_dly    = hist[S];
            m_hits   = (m_rel >= S + 1) ? (m_in_now & ~m_dly) : '0;
            m_wd     = data & MASK;
            if (clken && rden) m_q = readModel(address, m_in_now);
            if (clken && wren) begin
                case (address)
                    11'h000: m_out = m_wd;
                    11'h001: m_dir = m_wd;
                    11'h003: m_out = m_out | m_wd;
                    11'h004: m_out = m_out & ~m_wd;
                    11'h005: m_out = m_out ^ m_wd;
`ifdef GPIO_BANK_IRQ_EN
                    11'h006: m_ie = m_wd;
                    11'h007: m_iflag = m_iflag & ~m_wd;
`endif
                    default: ;
                endcase
            end
`ifdef GPIO_BANK_IRQ_EN
            m_iflag = m_iflag | {24'b0, m_hits};
`endif
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pin_in;
            if (m_rel < 1000) m_rel++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #2;
        if (compare_on) begin
            checkOutput("model_q", q, m_q);
            checkOutput("model_pin_out", {24'b0, pin_out}, m_out);
            checkOutput("model_pin_oe", {24'b0, pin_oe}, m_dir);
            checkOutput("model_irq", {31'b0, irq}, {31'b0, modelIrq()});
        end
    end

    task automatic applyStimulus(input logic [10:0] a, input logic [31:0] d,
                                 input logic rd, input logic wr, input logic ce);
        address = a; data = d; rden = rd; wren = wr; clken = ce;
        @(posedge clk);
        #3;
        rden = 1'b0; wren = 1'b0; clken = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    initial begin
        idle(3);
        compare_on = 1'b1;
        rst_n = 1'b1;
        checkOutput("reset_q", q, 32'h0);
        checkOutput("reset_pin_out", {24'b0, pin_out}, 32'h0);
        checkOutput("reset_pin_oe", {24'b0, pin_oe}, 32'h0);
        checkOutput("reset_irq", {31'b0, irq}, 32'h0);

        // Output register and its set/clear/toggle aliases.
        applyStimulus(11'h000, 32'h0000_00A5, 0, 1, 1);
        checkOutput("out_write", {24'b0, pin_out}, 32'hA5);
        applyStimulus(11'h003, 32'h0000_000F, 0, 1, 1);
        checkOutput("out_set", {24'b0, pin_out}, 32'hAF);
        applyStimulus(11'h004, 32'h0000_0081, 0, 1, 1);
        checkOutput("out_clr", {24'b0, pin_out}, 32'h2E);
        applyStimulus(11'h005, 32'h0000_00FF, 0, 1, 1);
        checkOutput("out_tgl", {24'b0, pin_out}, 32'hD1);
        applyStimulus(11'h000, 32'h0, 1, 0, 1);
        checkOutput("out_read", q, 32'h0000_00D1);

        // Read and write to the same word returns the old value.
        applyStimulus(11'h000, 32'hFFFF_FF12, 1, 1, 1);
        checkOutput("rdw_old_q", q, 32'h0000_00D1);
        checkOutput("rdw_new_out", {24'b0, pin_out}, 32'h12);

        // Unmapped and read-only writes have no effect; write-only reads are zero.
        applyStimulus(11'h400, 32'h0000_00FF, 0, 1, 1);
        applyStimulus(11'h002, 32'h0000_00FF, 0, 1, 1);
        checkOutput("unmapped_wr", {24'b0, pin_out}, 32'h12);
        applyStimulus(11'h003, 32'h0, 1, 0, 1);
        checkOutput("wo_read", q, 32'h0);

        // Synchronized input latency.
        pin_in = 8'h3C;
        applyStimulus(11'h002, 32'h0, 1, 0, 1);
        applyStimulus(11'h002, 32'h0, 1, 0, 1);
        checkOutput("in_early", q, 32'h0);
        applyStimulus(11'h002, 32'h0, 1, 0, 1);
        checkOutput("in_sync", q, 32'h0000_003C);
        pin_in = 8'h00;
        idle(4);

        // Qualifier gating of direction writes.
        applyStimulus(11'h001, 32'hFFFF_FFFF, 0, 1, 0);
        checkOutput("dir_noclken", {24'b0, pin_oe}, 32'h0);
        applyStimulus(11'h001, 32'hFFFF_FFFF, 0, 1, 1);
        checkOutput("dir_clken", {24'b0, pin_oe}, 32'hFF);
        applyStimulus(11'h001, 32'h0, 1, 0, 1);
        checkOutput("dir_read", q, 32'h0000_00FF);

`ifdef GPIO_BANK_IRQ_EN
        // Edge interrupt set, W1C, and set winning over a coincident clear.
        applyStimulus(11'h006, 32'h1, 0, 1, 1);
        pin_in = 8'h01;
        idle(3);
        checkOutput("irq_set", {31'b0, irq}, 32'h1);
        applyStimulus(11'h007, 32'h0, 1, 0, 1);
        checkOutput("iflag_set", q, 32'h1);
        applyStimulus(11'h007, 32'h1, 0, 1, 1);
        checkOutput("irq_clr", {31'b0, irq}, 32'h0);
        applyStimulus(11'h007, 32'h0, 1, 0, 1);
        checkOutput("iflag_clr", q, 32'h0);
        pin_in = 8'h00;
        idle(4);
        pin_in = 8'h01;
        idle(2);
        applyStimulus(11'h007, 32'h1, 0, 1, 1);
        checkOutput("w1c_vs_edge_irq", {31'b0, irq}, 32'h1);
        applyStimulus(11'h007, 32'h0, 1, 0, 1);
        checkOutput("w1c_vs_edge_flag", q, 32'h1);
        pin_in = 8'h00;
`else
        // Interrupt registers absent: writes ignored, reads zero, irq low.
        applyStimulus(11'h006, 32'hFF, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            pin_in = 8'(i[0] ? 8'hFF : 8'h00);
            idle(2);
            checkOutput("noirq_irq", {31'b0, irq}, 32'h0);
        end
        applyStimulus(11'h006, 32'h0, 1, 0, 1);
        checkOutput("noirq_ie_read", q, 32'h0);
        applyStimulus(11'h007, 32'h0, 1, 0, 1);
        checkOutput("noirq_iflag_read", q, 32'h0);
        pin_in = 8'h00;
`endif

        // Reset during a pending read clears q and the registers.
        applyStimulus(11'h001, 32'h0, 1, 0, 1);
        rst_n = 1'b0;
        applyStimulus(11'h001, 32'h0, 1, 1, 1);
        checkOutput("midreset_q", q, 32'h0);
        checkOutput("midreset_oe", {24'b0, pin_oe}, 32'h0);

        // Pins high across reset must not raise flags during the arm window.
        pin_in = 8'hFF;
        idle(2);
        rst_n = 1'b1;
        applyStimulus(11'h006, 32'hFF, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(11'h007, 32'h0, 1, 0, 1);
            checkOutput("arm_iflag", q, 32'h0);
            checkOutput("arm_irq", {31'b0, irq}, 32'h0);
        end

        // Randomized traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 500; n++) begin
            int r;
            logic [10:0] a;
            r = int'($urandom_range(0, 11));
            if (r < 8)       a = 11'(r);
            else if (r < 10) a = 11'h400 | 11'($urandom_range(0, 7));
            else             a = 11'($urandom_range(8, 2047));
            if ($urandom_range(0, 3) == 0) pin_in = 8'($urandom);
            rst_n = ($urandom_range(0, 79) != 0);
            applyStimulus(a, $urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end
        rst_n = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
